// File: rtl/vga_bus_arbiter_if.sv
// rtl/vga_bus_arbiter_if.sv - VGA/general requester and memory bus bundle for vga_bus_arbiter
// slave: the arbiter's view; master: the requesters plus memory driving it.
interface vga_bus_arbiter_if;
   logic [15:0] i_vga_addr;
   logic        i_vga_cs;
   logic [7:0]  o_vga_dat;
   logic        o_vga_ack;
   logic [15:0] i_gen_addr;
   logic [7:0]  i_gen_dat;
   logic        i_gen_we;
   logic        i_gen_cs;
   logic [7:0]  o_gen_dat;
   logic        o_gen_ack;
   logic        o_gen_err;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_dat;
   logic        o_mem_we;
   logic        o_mem_cs;
   logic [7:0]  i_mem_dat;
   logic        i_mem_ack;
   logic [1:0]  o_owner;

   modport slave (
      input  i_vga_addr, i_vga_cs, i_gen_addr, i_gen_dat, i_gen_we, i_gen_cs,
             i_mem_dat, i_mem_ack,
      output o_vga_dat, o_vga_ack, o_gen_dat, o_gen_ack, o_gen_err,
             o_mem_addr, o_mem_dat, o_mem_we, o_mem_cs, o_owner
   );

   modport master (
      output i_vga_addr, i_vga_cs, i_gen_addr, i_gen_dat, i_gen_we, i_gen_cs,
             i_mem_dat, i_mem_ack,
      input  o_vga_dat, o_vga_ack, o_gen_dat, o_gen_ack, o_gen_err,
             o_mem_addr, o_mem_dat, o_mem_we, o_mem_cs, o_owner
   );
endinterface

// File: rtl/vga_bus_arbiter.sv
// rtl/vga_bus_arbiter.sv - VGA-priority memory bus arbiter with general-master anti-starvation
// Optional busy timeout abort enabled by defining ARB_TIMEOUT_EN.
module vga_bus_arbiter #(
   parameter int GEN_MAX_WAIT = 8,
   parameter int TIMEOUT      = 255
) (
   input  logic             i_clk,
   input  logic             i_reset,
   vga_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VGA_BUSY = 2'd1,
      GEN_BUSY = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [3:0] MAX_WAIT = 4'(GEN_MAX_WAIT);
   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_VGA  = 2'b01;
   localparam logic [1:0] OWN_GEN  = 2'b10;

   if (GEN_MAX_WAIT < 1 || GEN_MAX_WAIT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("vga_bus_arbiter: parameter out of range");
   end

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_dat_q, mem_dat_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_cs_q, mem_cs_d;
   logic [7:0]  vga_dat_q, vga_dat_d;
   logic        vga_ack_q, vga_ack_d;
   logic [7:0]  gen_dat_q, gen_dat_d;
   logic        gen_ack_q, gen_ack_d;
   logic [1:0]  owner_q, owner_d;
   logic        forced, vga_win, gen_win, tmo_hit;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       gen_err_q, gen_err_d;

   // tmo_cnt_q counts earlier ack-less cycles, so this is the TIMEOUT-th busy cycle
   assign tmo_hit       = !bus.i_mem_ack && (tmo_cnt_q == TMO_LAST);
   assign bus.o_gen_err = gen_err_q;
`else
   assign tmo_hit       = 1'b0;
   assign bus.o_gen_err = 1'b0;
`endif

   always_comb begin
      forced  = (wait_cnt_q == MAX_WAIT) && bus.i_gen_cs;
      vga_win = bus.i_vga_cs && !forced;
      gen_win = !vga_win && bus.i_gen_cs;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (vga_win)      state_d = VGA_BUSY;
            else if (gen_win) state_d = GEN_BUSY;
         end
         VGA_BUSY, GEN_BUSY: begin
            if (bus.i_mem_ack || tmo_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      mem_addr_d = mem_addr_q;
      mem_dat_d  = mem_dat_q;
      mem_we_d   = mem_we_q;
      mem_cs_d   = mem_cs_q;
      vga_dat_d  = vga_dat_q;
      vga_ack_d  = 1'b0;
      gen_dat_d  = gen_dat_q;
      gen_ack_d  = 1'b0;
      owner_d    = owner_q;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      gen_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_d = 8'd0;
`endif
            if (!bus.i_gen_cs)                    wait_cnt_d = 4'd0;
            else if (vga_win && wait_cnt_q != MAX_WAIT) wait_cnt_d = wait_cnt_q + 4'd1;
            else if (!vga_win)                    wait_cnt_d = 4'd0;
            if (vga_win) begin
               mem_cs_d   = 1'b1;
               mem_addr_d = bus.i_vga_addr;
               mem_dat_d  = 8'h00;
               mem_we_d   = 1'b0;
               owner_d    = OWN_VGA;
            end else if (gen_win) begin
               mem_cs_d   = 1'b1;
               mem_addr_d = bus.i_gen_addr;
               mem_dat_d  = bus.i_gen_dat;
               mem_we_d   = bus.i_gen_we;
               owner_d    = OWN_GEN;
            end
         end
         VGA_BUSY: begin
            if (bus.i_mem_ack || tmo_hit) begin
               mem_cs_d  = 1'b0;
               mem_we_d  = 1'b0;
               vga_ack_d = 1'b1;
               vga_dat_d = bus.i_mem_ack ? bus.i_mem_dat : 8'hFF;
               owner_d   = OWN_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
         end
         GEN_BUSY: begin
            if (bus.i_mem_ack || tmo_hit) begin
               mem_cs_d  = 1'b0;
               mem_we_d  = 1'b0;
               gen_ack_d = 1'b1;
               if (!bus.i_mem_ack) gen_dat_d = 8'hFF;
               else if (mem_we_q)  gen_dat_d = 8'h00;
               else                gen_dat_d = bus.i_mem_dat;
               owner_d   = OWN_IDLE;
`ifdef ARB_TIMEOUT_EN
               gen_err_d = !bus.i_mem_ack;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
         end
         DONE: begin
            owner_d = OWN_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wait_cnt_q <= 4'd0;
         mem_addr_q <= 16'h0000;
         mem_dat_q  <= 8'h00;
         mem_we_q   <= 1'b0;
         mem_cs_q   <= 1'b0;
         vga_dat_q  <= 8'h00;
         vga_ack_q  <= 1'b0;
         gen_dat_q  <= 8'h00;
         gen_ack_q  <= 1'b0;
         owner_q    <= OWN_IDLE;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q  <= 8'd0;
         gen_err_q  <= 1'b0;
`endif
      end else begin
         wait_cnt_q <= wait_cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_dat_q  <= mem_dat_d;
         mem_we_q   <= mem_we_d;
         mem_cs_q   <= mem_cs_d;
         vga_dat_q  <= vga_dat_d;
         vga_ack_q  <= vga_ack_d;
         gen_dat_q  <= gen_dat_d;
         gen_ack_q  <= gen_ack_d;
         owner_q    <= owner_d;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q  <= tmo_cnt_d;
         gen_err_q  <= gen_err_d;
`endif
      end
   end

   assign bus.o_mem_addr = mem_addr_q;
   assign bus.o_mem_dat  = mem_dat_q;
   assign bus.o_mem_we   = mem_we_q;
   assign bus.o_mem_cs   = mem_cs_q;
   assign bus.o_vga_dat  = vga_dat_q;
   assign bus.o_vga_ack  = vga_ack_q;
   assign bus.o_gen_dat  = gen_dat_q;
   assign bus.o_gen_ack  = gen_ack_q;
   assign bus.o_owner    = owner_q;
endmodule

// File: tb/tb_vga_bus_arbiter.sv
// tb/tb_vga_bus_arbiter.sv - scoreboard bench for vga_bus_arbiter
// Memory responder and ack monitor run alongside; scenario tasks compare inline.
module tb_vga_bus_arbiter;
   logic i_clk = 1'b0;
   logic i_reset;
   always #5 i_clk = ~i_clk;

   vga_bus_arbiter_if bus();

   vga_bus_arbiter #(.GEN_MAX_WAIT(8), .TIMEOUT(255)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   typedef struct packed {
      logic       vga;
      logic [7:0] dat;
      logic       err;
      int         cyc;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        obs_q[$];
   logic [1:0]  own_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [7:0]  mem [0:65535];
   int          mem_delay = 0;
   bit          mem_never = 1'b0;
   int          cs_cycles, we_cycles, last_cs_len, last_we_len;
   logic [15:0] first_addr;
   logic [7:0]  first_dat;
   bit          stable;
   bit          own_log_en = 1'b0;
   int          ack_twice = 0;

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // memory model: acks after mem_delay extra cs cycles, records transfer shape
   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h96;
      mem[16'h0123] = 8'h5A;
      bus.i_mem_ack = 1'b0;
      bus.i_mem_dat = 8'h00;
      cs_cycles = 0; we_cycles = 0; last_cs_len = 0; last_we_len = 0;
      first_addr = '0; first_dat = '0; stable = 1'b1;
      forever begin
         @(negedge i_clk);
         if (i_reset || !bus.o_mem_cs) begin
            if (cs_cycles != 0) begin
               last_cs_len = cs_cycles;
               last_we_len = we_cycles;
            end
            cs_cycles = 0;
            we_cycles = 0;
            bus.i_mem_ack = 1'b0;
         end else begin
            cs_cycles++;
            if (bus.o_mem_we) we_cycles++;
            if (cs_cycles == 1) begin
               first_addr = bus.o_mem_addr;
               first_dat  = bus.o_mem_dat;
               stable     = 1'b1;
            end else if (bus.o_mem_addr !== first_addr || bus.o_mem_dat !== first_dat) begin
               stable = 1'b0;
            end
            if (!mem_never && cs_cycles == mem_delay + 1) begin
               bus.i_mem_ack = 1'b1;
               if (bus.o_mem_we) begin
                  mem[bus.o_mem_addr] = bus.o_mem_dat;
                  bus.i_mem_dat = 8'hEE;
               end else begin
                  bus.i_mem_dat = mem[bus.o_mem_addr];
               end
            end else begin
               bus.i_mem_ack = 1'b0;
               bus.i_mem_dat = 8'h77;
            end
         end
      end
   end

   initial begin
      logic pv, pg;
      pv = 1'b0; pg = 1'b0;
      forever begin
         @(negedge i_clk);
         if (bus.o_vga_ack) obs_q.push_back('{vga: 1'b1, dat: bus.o_vga_dat, err: bus.o_gen_err, cyc: cyc});
         if (bus.o_gen_ack) obs_q.push_back('{vga: 1'b0, dat: bus.o_gen_dat, err: bus.o_gen_err, cyc: cyc});
         if ((bus.o_vga_ack && pv) || (bus.o_gen_ack && pg)) ack_twice++;
         pv = bus.o_vga_ack;
         pg = bus.o_gen_ack;
         if (own_log_en) own_q.push_back(bus.o_owner);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_obs(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (obs_q.size() > 0) begin
            ok = 1'b1;
            return;
         end
         @(negedge i_clk); #1;
      end
      ok = (obs_q.size() > 0);
   endtask

   function automatic logic [46:0] all_outs();
      return {bus.o_vga_dat, bus.o_vga_ack, bus.o_gen_dat, bus.o_gen_ack, bus.o_gen_err,
              bus.o_mem_addr, bus.o_mem_dat, bus.o_mem_we, bus.o_mem_cs, bus.o_owner};
   endfunction

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      tests++;
      if (all_outs() !== 47'd0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
      end
      i_reset = 1'b0;
      repeat (2) @(negedge i_clk);
      #1;
      tests++;
      if ({bus.o_mem_cs, bus.o_owner} !== 3'b000 || obs_q.size() != 0) begin
         fails++; $display("FAIL reset_idle: cs=%b owner=%b acks=%0d expected 0", bus.o_mem_cs, bus.o_owner, obs_q.size());
      end
   endtask

   task automatic test_vga_read();
      rec_t e, o;
      bit ok;
      int t0;
      mem_delay = 0;
      bus.i_vga_addr = 16'h0123;
      bus.i_vga_cs = 1'b1;
      t0 = cyc;
      e = '{vga: 1'b1, dat: mem[16'h0123], err: 1'b0, cyc: 0};
      exp_q.push_back(e);
      wait_obs(20, ok);
      bus.i_vga_cs = 1'b0;
      tests++;
      if (!ok) begin
         fails++; $display("FAIL vga_read_done: got no ack in 20 cycles expected ack");
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if ({o.vga, o.dat, o.err} !== {e.vga, e.dat, e.err}) begin
            fails++; $display("FAIL vga_read_data: got vga=%b dat=%h err=%b expected vga=%b dat=%h err=%b", o.vga, o.dat, o.err, e.vga, e.dat, e.err);
         end
         tests++;
         if (o.cyc - t0 != 2) begin
            fails++; $display("FAIL vga_read_latency: got %0d expected 2", o.cyc - t0);
         end
      end
      @(negedge i_clk); #1;
      tests++;
      if (bus.o_vga_ack !== 1'b0) begin
         fails++; $display("FAIL vga_ack_width: got ack=%b expected 0", bus.o_vga_ack);
      end
      tests++;
      if ({last_cs_len, last_we_len, first_addr} !== {32'd1, 32'd0, 16'h0123}) begin
         fails++; $display("FAIL vga_mem_cycle: got cs_len=%0d we_len=%0d addr=%h expected 1 0 0123", last_cs_len, last_we_len, first_addr);
      end
      exp_q.delete();
   endtask

   task automatic test_gen_write();
      rec_t e, o;
      bit ok;
      mem_delay = 4;
      bus.i_gen_addr = 16'hFFF0;
      bus.i_gen_dat = 8'h3C;
      bus.i_gen_we = 1'b1;
      bus.i_gen_cs = 1'b1;
      exp_q.push_back('{vga: 1'b0, dat: 8'h00, err: 1'b0, cyc: 0});
      wait_obs(30, ok);
      bus.i_gen_cs = 1'b0;
      bus.i_gen_we = 1'b0;
      tests++;
      if (!ok) begin
         fails++; $display("FAIL gen_write_done: got no ack in 30 cycles expected ack");
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if ({o.vga, o.dat, o.err} !== {e.vga, e.dat, e.err}) begin
            fails++; $display("FAIL gen_write_resp: got vga=%b dat=%h err=%b expected vga=%b dat=%h err=%b", o.vga, o.dat, o.err, e.vga, e.dat, e.err);
         end
      end
      @(negedge i_clk); #1;
      tests++;
      if (last_cs_len != 5 || last_we_len != 5 || !stable) begin
         fails++; $display("FAIL gen_write_shape: got cs_len=%0d we_len=%0d stable=%b expected 5 5 1", last_cs_len, last_we_len, stable);
      end
      tests++;
      if ({first_addr, first_dat, mem[16'hFFF0]} !== {16'hFFF0, 8'h3C, 8'h3C}) begin
         fails++; $display("FAIL gen_write_bus: got addr=%h dat=%h stored=%h expected fff0 3c 3c", first_addr, first_dat, mem[16'hFFF0]);
      end
      mem_delay = 0;
      exp_q.delete();
   endtask

   task automatic test_simultaneous();
      rec_t e, o;
      int n, idx;
      logic [7:0] seq;
      own_q.delete();
      own_log_en = 1'b1;
      bus.i_vga_addr = 16'h0200;
      bus.i_gen_addr = 16'h0300;
      bus.i_gen_we = 1'b0;
      bus.i_vga_cs = 1'b1;
      bus.i_gen_cs = 1'b1;
      exp_q.push_back('{vga: 1'b1, dat: mem[16'h0200], err: 1'b0, cyc: 0});
      exp_q.push_back('{vga: 1'b0, dat: mem[16'h0300], err: 1'b0, cyc: 0});
      n = 0;
      for (int i = 0; i < 30 && n < 2; i++) begin
         @(negedge i_clk); #1;
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n++;
            if (o.vga) bus.i_vga_cs = 1'b0;
            else       bus.i_gen_cs = 1'b0;
            tests++;
            if ({o.vga, o.dat, o.err} !== {e.vga, e.dat, e.err}) begin
               fails++; $display("FAIL simul_order: got vga=%b dat=%h err=%b expected vga=%b dat=%h err=%b", o.vga, o.dat, o.err, e.vga, e.dat, e.err);
            end
         end
      end
      bus.i_vga_cs = 1'b0;
      bus.i_gen_cs = 1'b0;
      own_log_en = 1'b0;
      tests++;
      if (n != 2) begin
         fails++; $display("FAIL simul_done: got %0d acks expected 2", n);
      end
      idx = -1;
      for (int i = 0; i < own_q.size(); i++) if (idx < 0 && own_q[i] == 2'b01) idx = i;
      seq = 8'hFF;
      if (idx >= 0 && idx + 3 < own_q.size()) seq = {own_q[idx], own_q[idx+1], own_q[idx+2], own_q[idx+3]};
      tests++;
      if (seq !== 8'b01_00_00_10) begin
         fails++; $display("FAIL simul_owner_seq: got %b expected 01000010", seq);
      end
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge i_clk); #1;
   endtask

   task automatic test_back_to_back();
      rec_t o;
      int stamps[$];
      bus.i_vga_addr = 16'h0210;
      bus.i_vga_cs = 1'b1;
      for (int i = 0; i < 40 && stamps.size() < 3; i++) begin
         @(negedge i_clk); #1;
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            stamps.push_back(o.cyc);
            tests++;
            if ({o.vga, o.dat} !== {1'b1, mem[16'h0210]}) begin
               fails++; $display("FAIL b2b_data: got vga=%b dat=%h expected vga=1 dat=%h", o.vga, o.dat, mem[16'h0210]);
            end
         end
         if (stamps.size() >= 3) bus.i_vga_cs = 1'b0;
      end
      bus.i_vga_cs = 1'b0;
      tests++;
      if (stamps.size() != 3) begin
         fails++; $display("FAIL b2b_count: got %0d acks expected 3", stamps.size());
      end else begin
         tests++;
         if (stamps[1] - stamps[0] != 3 || stamps[2] - stamps[1] != 3) begin
            fails++; $display("FAIL b2b_spacing: got %0d %0d expected 3 3", stamps[1] - stamps[0], stamps[2] - stamps[1]);
         end
      end
      repeat (2) @(negedge i_clk); #1;
      obs_q.delete();
   endtask

   task automatic test_starvation();
      rec_t e, o;
      int n_vga;
      bit gen_done;
      bus.i_vga_addr = 16'h0220;
      bus.i_gen_addr = 16'h0330;
      bus.i_gen_we = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back('{vga: 1'b1, dat: mem[16'h0220], err: 1'b0, cyc: 0});
      exp_q.push_back('{vga: 1'b0, dat: mem[16'h0330], err: 1'b0, cyc: 0});
      bus.i_vga_cs = 1'b1;
      bus.i_gen_cs = 1'b1;
      n_vga = 0;
      gen_done = 1'b0;
      for (int i = 0; i < 200 && !gen_done; i++) begin
         @(negedge i_clk); #1;
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            tests++;
            if ({o.vga, o.dat, o.err} !== {e.vga, e.dat, e.err}) begin
               fails++; $display("FAIL starve_seq: got vga=%b dat=%h err=%b expected vga=%b dat=%h err=%b", o.vga, o.dat, o.err, e.vga, e.dat, e.err);
            end
            if (o.vga) n_vga++;
            else begin
               gen_done = 1'b1;
               bus.i_vga_cs = 1'b0;
               bus.i_gen_cs = 1'b0;
            end
         end
      end
      bus.i_vga_cs = 1'b0;
      bus.i_gen_cs = 1'b0;
      tests++;
      if (!gen_done || n_vga != 8) begin
         fails++; $display("FAIL starve_count: got gen_done=%b vga_before=%0d expected 1 8", gen_done, n_vga);
      end
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge i_clk); #1;
   endtask

   task automatic test_timeout();
      bit ok;
      rec_t o;
      mem_never = 1'b1;
      bus.i_gen_addr = 16'h0042;
      bus.i_gen_we = 1'b0;
      bus.i_gen_cs = 1'b1;
`ifdef ARB_TIMEOUT_EN
      exp_q.push_back('{vga: 1'b0, dat: 8'hFF, err: 1'b1, cyc: 0});
      wait_obs(400, ok);
      bus.i_gen_cs = 1'b0;
      tests++;
      if (!ok) begin
         fails++; $display("FAIL timeout_done: got no ack in 400 cycles expected abort");
      end else begin
         o = obs_q.pop_front();
         tests++;
         if ({o.vga, o.dat, o.err} !== {exp_q[0].vga, exp_q[0].dat, exp_q[0].err}) begin
            fails++; $display("FAIL timeout_resp: got vga=%b dat=%h err=%b expected vga=0 dat=ff err=1", o.vga, o.dat, o.err);
         end
      end
      @(negedge i_clk); #1;
      tests++;
      if (last_cs_len != 255) begin
         fails++; $display("FAIL timeout_len: got %0d expected 255", last_cs_len);
      end
      mem_never = 1'b0;
`else
      wait_obs(300, ok);
      tests++;
      if (ok || bus.o_mem_cs !== 1'b1 || bus.o_owner !== 2'b10) begin
         fails++; $display("FAIL no_timeout_hold: got ack=%b cs=%b owner=%b expected 0 1 10", ok, bus.o_mem_cs, bus.o_owner);
      end
      bus.i_gen_cs = 1'b0;
      i_reset = 1'b1;
      mem_never = 1'b0;
      repeat (2) @(negedge i_clk); #1;
      i_reset = 1'b0;
`endif
      exp_q.delete();
      obs_q.delete();
      repeat (2) @(negedge i_clk); #1;
   endtask

   task automatic test_reset_mid();
      mem_delay = 10;
      bus.i_gen_addr = 16'h0400;
      bus.i_gen_we = 1'b0;
      bus.i_gen_cs = 1'b1;
      repeat (3) @(negedge i_clk);
      #1;
      tests++;
      if (bus.o_mem_cs !== 1'b1 || bus.o_owner !== 2'b10) begin
         fails++; $display("FAIL reset_mid_busy: got cs=%b owner=%b expected 1 10", bus.o_mem_cs, bus.o_owner);
      end
      #2;
      i_reset = 1'b1;
      #1;
      tests++;
      if (all_outs() !== 47'd0) begin
         fails++; $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
      end
      bus.i_gen_cs = 1'b0;
      repeat (2) @(negedge i_clk); #1;
      i_reset = 1'b0;
      mem_delay = 0;
      repeat (15) @(negedge i_clk); #1;
      tests++;
      if (obs_q.size() != 0) begin
         fails++; $display("FAIL reset_mid_no_ack: got %0d acks expected 0", obs_q.size());
      end
      obs_q.delete();
      test_vga_read();
      tests++;
      if (ack_twice != 0) begin
         fails++; $display("FAIL ack_pulse: got %0d long acks expected 0", ack_twice);
      end
   endtask

   initial begin
      i_reset = 1'b1;
      bus.i_vga_addr = '0;
      bus.i_vga_cs = 1'b0;
      bus.i_gen_addr = '0;
      bus.i_gen_dat = '0;
      bus.i_gen_we = 1'b0;
      bus.i_gen_cs = 1'b0;
      test_reset();
      test_vga_read();
      test_gen_write();
      test_simultaneous();
      test_back_to_back();
      test_starvation();
      test_simultaneous();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
